// File: rtl/wb_retire_queue.sv
// In-order writeback retire queue: buffers MEM results, drains one entry per cycle to the
// regfile when it is ready, drives the debug trace and answers youngest-match forwarding lookups.
module wb_retire_queue #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4,
  localparam int BE_W  = DATA_W / 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              to_wb_valid,
  input  logic [31:0]       pc,
  input  logic [BE_W-1:0]   rf_we,
  input  logic [ADDR_W-1:0] rf_waddr,
  input  logic [DATA_W-1:0] rf_wdata,
  output logic              wb_allow_in,
  input  logic              rf_ready,
  output logic [BE_W-1:0]   rf_we_out,
  output logic [ADDR_W-1:0] rf_waddr_out,
  output logic [DATA_W-1:0] rf_wdata_out,
  input  logic [ADDR_W-1:0] fwd_raddr,
  output logic              fwd_hit,
  output logic [BE_W-1:0]   fwd_be,
  output logic [DATA_W-1:0] fwd_data,
  output logic [31:0]       debug_wb_pc,
  output logic [BE_W-1:0]   debug_wb_rf_we,
  output logic [ADDR_W-1:0] debug_wb_rf_wnum,
  output logic [DATA_W-1:0] debug_wb_rf_wdata,
  output logic [PTR_W:0]    wb_count
);

  logic [31:0]       pc_mem    [DEPTH];
  logic [BE_W-1:0]   we_mem    [DEPTH];
  logic [ADDR_W-1:0] waddr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem  [DEPTH];

  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PTR_W:0]   count_reg, count_next;

  logic head_valid;
  logic push;
  logic pop;
  logic retire;

  assign head_valid  = (count_reg != '0);
  assign wb_allow_in = (count_reg != (PTR_W+1)'(DEPTH));
  assign push        = to_wb_valid & wb_allow_in;
  // Nothing retires while reset is asserted, even if entries are still queued.
  assign retire      = head_valid & rf_ready & ~reset;
  assign pop         = retire;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (push) wr_ptr_next = wr_ptr_reg + 1'b1;
    if (pop)  rd_ptr_next = rd_ptr_reg + 1'b1;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Payload storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_reg]    <= pc;
      we_mem[wr_ptr_reg]    <= rf_we;
      waddr_mem[wr_ptr_reg] <= rf_waddr;
      data_mem[wr_ptr_reg]  <= rf_wdata;
    end
  end

  always_comb begin
    rf_we_out = '0;
    if (retire && waddr_mem[rd_ptr_reg] != '0) rf_we_out = we_mem[rd_ptr_reg];
  end

  assign rf_waddr_out      = head_valid ? waddr_mem[rd_ptr_reg] : '0;
  assign rf_wdata_out      = head_valid ? data_mem[rd_ptr_reg]  : '0;
  assign debug_wb_pc       = head_valid ? pc_mem[rd_ptr_reg]    : '0;
  assign debug_wb_rf_we    = rf_we_out;
  assign debug_wb_rf_wnum  = rf_waddr_out;
  assign debug_wb_rf_wdata = rf_wdata_out;
  assign wb_count          = count_reg;

  // Slot gi is the gi-th oldest entry; it matches when occupied and writing fwd_raddr.
  logic [PTR_W-1:0] slot_idx [DEPTH];
  logic [DEPTH-1:0] slot_match;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      assign slot_idx[gi]   = rd_ptr_reg + PTR_W'(gi);
      assign slot_match[gi] = ((PTR_W+1)'(gi) < count_reg)
                              && (we_mem[slot_idx[gi]] != '0)
                              && (waddr_mem[slot_idx[gi]] == fwd_raddr);
    end
  endgenerate

  // Later slots overwrite earlier ones, so the youngest matching entry wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_be   = '0;
    fwd_data = '0;
    if (fwd_raddr != '0) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (slot_match[i]) begin
          fwd_hit  = 1'b1;
          fwd_be   = we_mem[slot_idx[i]];
          fwd_data = data_mem[slot_idx[i]];
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_retire_queue.sv
// Scoreboard bench for wb_retire_queue: stimulus queues expected retirements, a negedge
// monitor pops and compares whenever the DUT retires an entry.
module tb_wb_retire_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        to_wb_valid = 1'b0;
  logic [31:0] pc = '0;
  logic [3:0]  rf_we = '0;
  logic [4:0]  rf_waddr = '0;
  logic [31:0] rf_wdata = '0;
  logic        wb_allow_in;
  logic        rf_ready = 1'b0;
  logic [3:0]  rf_we_out;
  logic [4:0]  rf_waddr_out;
  logic [31:0] rf_wdata_out;
  logic [4:0]  fwd_raddr = '0;
  logic        fwd_hit;
  logic [3:0]  fwd_be;
  logic [31:0] fwd_data;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_we;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;
  logic [2:0]  wb_count;

  always #5 clk = ~clk;

  wb_retire_queue #(.DATA_W(32), .ADDR_W(5), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .to_wb_valid(to_wb_valid), .pc(pc), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .wb_allow_in(wb_allow_in), .rf_ready(rf_ready),
    .rf_we_out(rf_we_out), .rf_waddr_out(rf_waddr_out), .rf_wdata_out(rf_wdata_out),
    .fwd_raddr(fwd_raddr), .fwd_hit(fwd_hit), .fwd_be(fwd_be), .fwd_data(fwd_data),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata),
    .wb_count(wb_count)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  we;
    logic [4:0]  waddr;
    logic [31:0] data;
  } entry_t;

  entry_t exp_q[$];
  entry_t mon_e;
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every cycle with an occupied queue and rf_ready is a retirement.
  always @(negedge clk) begin
    if (reset) begin
      chk("reset_rf_we_out", 64'(rf_we_out), 64'h0);
    end else if (wb_count != 3'd0 && rf_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_retire", 64'(debug_wb_pc), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        chk("retire_pc", 64'(debug_wb_pc), 64'(mon_e.pc));
        chk("retire_we", 64'(rf_we_out), (mon_e.waddr == 5'd0) ? 64'h0 : 64'(mon_e.we));
        chk("retire_waddr", 64'(rf_waddr_out), 64'(mon_e.waddr));
        chk("retire_data", 64'(rf_wdata_out), 64'(mon_e.data));
        chk("trace_we", 64'(debug_wb_rf_we), (mon_e.waddr == 5'd0) ? 64'h0 : 64'(mon_e.we));
        chk("trace_wnum", 64'(debug_wb_rf_wnum), 64'(mon_e.waddr));
        $display("retire pc=%08h we=%h waddr=%0d data=%08h", debug_wb_pc, rf_we_out,
                 rf_waddr_out, rf_wdata_out);
      end
    end else begin
      chk("idle_rf_we_out", 64'(rf_we_out), 64'h0);
      chk("idle_trace_we", 64'(debug_wb_rf_we), 64'h0);
      if (wb_count == 3'd0) chk("idle_trace_pc", 64'(debug_wb_pc), 64'h0);
    end
  end

  // Presents one entry and holds it until accepted; the expected retirement is queued on acceptance.
  task automatic push_entry(input logic [31:0] p, input logic [3:0] w, input logic [4:0] a,
                            input logic [31:0] d);
    int k;
    entry_t e;
    to_wb_valid = 1'b1;
    pc = p; rf_we = w; rf_waddr = a; rf_wdata = d;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (wb_allow_in) break;
    end
    if (k == 50) begin
      n_chk++; n_fail++;
      $display("FAIL push_timeout: pc=%08h never accepted, required acceptance within 50 cycles", p);
    end else begin
      e.pc = p; e.we = w; e.waddr = a; e.data = d;
      exp_q.push_back(e);
      $display("push   pc=%08h we=%h waddr=%0d data=%08h", p, w, a, d);
    end
    @(posedge clk); #1;
    to_wb_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int k;
    for (k = 0; k < 50; k++) begin
      if (wb_count == 3'd0) break;
      @(posedge clk); #1;
    end
    chk("drain_count", 64'(wb_count), 64'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_count", 64'(wb_count), 64'h0);
    chk("reset_allow_in", 64'(wb_allow_in), 64'h1);
    chk("reset_fwd_hit", 64'(fwd_hit), 64'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    // 1: single entry retires the next cycle; retiring entry is still forwardable
    rf_ready = 1'b1;
    push_entry(32'h1c00_0000, 4'hF, 5'd3, 32'h1234_5678);
    chk("t1_count_after_push", 64'(wb_count), 64'h1);
    fwd_raddr = 5'd3;
    @(negedge clk);
    chk("t1_fwd_hit_popping", 64'(fwd_hit), 64'h1);
    chk("t1_fwd_be", 64'(fwd_be), 64'hF);
    chk("t1_fwd_data", 64'(fwd_data), 64'h1234_5678);
    @(posedge clk); #1;
    chk("t1_count_back_to_0", 64'(wb_count), 64'h0);
    fwd_raddr = 5'd0;

    // 2: fill while the regfile is busy, 5th entry held until space frees up
    rf_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      push_entry(32'h1c00_0010 + 32'(4 * i), 4'hF, 5'(10 + i), 32'h0000_0a00 + 32'(i));
    chk("t2_full_count", 64'(wb_count), 64'h4);
    chk("t2_full_allow_in", 64'(wb_allow_in), 64'h0);
    fork
      push_entry(32'h1c00_0020, 4'h1, 5'd14, 32'h0000_0a04);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("t2_held_allow_in", 64'(wb_allow_in), 64'h0);
          chk("t2_held_count", 64'(wb_count), 64'h4);
        end
        @(posedge clk); #1;
        rf_ready = 1'b1;
        @(posedge clk); #1;
        chk("t2_allow_after_pop", 64'(wb_allow_in), 64'h1);
      end
    join
    wait_empty();

    // 3: youngest match wins; r0 lookup and unrelated register miss
    rf_ready = 1'b0;
    push_entry(32'h1c00_0100, 4'hF, 5'd5, 32'h0000_0011);
    push_entry(32'h1c00_0104, 4'h3, 5'd5, 32'h0000_0022);
    fwd_raddr = 5'd5;
    @(negedge clk);
    chk("t3_fwd_hit", 64'(fwd_hit), 64'h1);
    chk("t3_fwd_be", 64'(fwd_be), 64'h3);
    chk("t3_fwd_data", 64'(fwd_data), 64'h22);
    fwd_raddr = 5'd0;
    #1;
    chk("t3_fwd_r0_hit", 64'(fwd_hit), 64'h0);
    chk("t3_fwd_r0_be", 64'(fwd_be), 64'h0);
    fwd_raddr = 5'd9;
    #1;
    chk("t3_fwd_miss_hit", 64'(fwd_hit), 64'h0);
    chk("t3_fwd_miss_data", 64'(fwd_data), 64'h0);
    fwd_raddr = 5'd0;
    @(posedge clk); #1;
    rf_ready = 1'b1;
    wait_empty();

    // 4: write to r0 retires without a write enable
    push_entry(32'h1c00_0200, 4'hF, 5'd0, 32'hdead_beef);
    wait_empty();

    // 5: push and pop every cycle across several pointer wraps
    for (int i = 0; i < 11; i++) begin
      push_entry(32'h1c00_1000 + 32'(4 * i), 4'hF, 5'(i + 1), 32'ha000_0000 + 32'(i));
      chk("t5_steady_count", 64'(wb_count), 64'h1);
    end
    wait_empty();

    // 6: reset with entries queued discards them
    rf_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      push_entry(32'h1c00_2000 + 32'(4 * i), 4'hF, 5'(20 + i), 32'hb000_0000 + 32'(i));
    chk("t6_count_before_reset", 64'(wb_count), 64'h3);
    reset = 1'b1;
    rf_ready = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    chk("t6_count_after_reset", 64'(wb_count), 64'h0);
    chk("t6_we_after_reset", 64'(rf_we_out), 64'h0);
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("t6_count_after_release", 64'(wb_count), 64'h0);
    chk("t6_allow_after_release", 64'(wb_allow_in), 64'h1);
    chk("final_scoreboard_empty", 64'(exp_q.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
